// File: rtl/proc_ctrl_seq_if.sv
// Handshake and datapath-control bundle between an instruction source and proc_ctrl_seq.
// master = instruction source, slave = sequencer.
interface proc_ctrl_seq_if #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 3
);
    logic                start;
    logic [3:0]          func;
    logic [IDX_W-1:0]    rx;
    logic [IDX_W-1:0]    ry;
    logic                busy;
    logic                done;
    logic                err;
    logic                data_out;
    logic [NUM_REGS-1:0] r_in;
    logic [NUM_REGS-1:0] r_out;
    logic                a_in;
    logic                g_in;
    logic                g_out;
    logic [2:0]          alu_op;

    modport master (
        output start, func, rx, ry,
        input  busy, done, err, data_out, r_in, r_out, a_in, g_in, g_out, alu_op
    );

    modport slave (
        input  start, func, rx, ry,
        output busy, done, err, data_out, r_in, r_out, a_in, g_in, g_out, alu_op
    );
endinterface

// File: rtl/proc_ctrl_seq.sv
// Control sequencer for the simple processor datapath: one instruction per start/done handshake.
// Optional macro LOGIC_OPS_EN adds AND (0110) and OR (0111) as three-step ALU ops.
//
//  state  | meaning
//  S_IDLE | waiting for start; all outputs 0
//  S_T1   | LOAD/MOVE single step, or ALU step 1 (rx -> A)
//  S_T2   | ALU step 2 (ry through ALU -> G)
//  S_T3   | ALU step 3 (G -> rx), done
//  S_ERR  | illegal instruction: done + err, no enables
module proc_ctrl_seq #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    proc_ctrl_seq_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_ERR} state_t;

    localparam logic [3:0] F_LOAD = 4'b0001;
    localparam logic [3:0] F_MOVE = 4'b0010;
    localparam logic [3:0] F_ADD  = 4'b0011;
    localparam logic [3:0] F_SUB  = 4'b0100;
    localparam logic [3:0] F_XOR  = 4'b0101;
    localparam logic [3:0] F_AND  = 4'b0110;
    localparam logic [3:0] F_OR   = 4'b0111;

    // One extra bit so an index equal to NUM_REGS never wraps onto register 0.
    localparam logic [IDX_W:0] NR = (IDX_W+1)'(NUM_REGS);

    state_t           state, state_nxt;
    logic [3:0]       func_q;
    logic [IDX_W-1:0] rx_q, ry_q;
    logic             rx_ok, ry_ok, legal;

    function automatic logic is_alu(input logic [3:0] f);
`ifdef LOGIC_OPS_EN
        return (f == F_ADD) || (f == F_SUB) || (f == F_XOR) || (f == F_AND) || (f == F_OR);
`else
        return (f == F_ADD) || (f == F_SUB) || (f == F_XOR);
`endif
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] f);
        logic [2:0] c;
        c = 3'b000;
        case (f)
            F_SUB:   c = 3'b001;
            F_XOR:   c = 3'b010;
`ifdef LOGIC_OPS_EN
            F_AND:   c = 3'b011;
            F_OR:    c = 3'b100;
`endif
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++)
            r[i] = ({1'b0, idx} == (IDX_W+1)'(i));
        return r;
    endfunction

    assign rx_ok = {1'b0, bus.rx} < NR;
    assign ry_ok = {1'b0, bus.ry} < NR;
    assign legal = rx_ok && ((bus.func == F_LOAD) ||
                             (((bus.func == F_MOVE) || is_alu(bus.func)) && ry_ok));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            func_q <= '0;
            rx_q   <= '0;
            ry_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus.start) begin
                func_q <= bus.func;
                rx_q   <= bus.rx;
                ry_q   <= bus.ry;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        bus.data_out = 1'b0;
        bus.r_in     = '0;
        bus.r_out    = '0;
        bus.a_in     = 1'b0;
        bus.g_in     = 1'b0;
        bus.g_out    = 1'b0;
        bus.alu_op   = 3'b000;
        case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start)
                    state_nxt = legal ? S_T1 : S_ERR;
            end
            S_T1: begin
                bus.alu_op = alu_code(func_q);
                if (func_q == F_LOAD) begin
                    bus.data_out = 1'b1;
                    bus.r_in     = onehot(rx_q);
                    bus.done     = 1'b1;
                    state_nxt    = S_IDLE;
                end else if (func_q == F_MOVE) begin
                    bus.r_out = onehot(ry_q);
                    bus.r_in  = onehot(rx_q);
                    bus.done  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    bus.r_out = onehot(rx_q);
                    bus.a_in  = 1'b1;
                    state_nxt = S_T2;
                end
            end
            S_T2: begin
                bus.alu_op = alu_code(func_q);
                bus.r_out  = onehot(ry_q);
                bus.g_in   = 1'b1;
                state_nxt  = S_T3;
            end
            S_T3: begin
                bus.alu_op = alu_code(func_q);
                bus.g_out  = 1'b1;
                bus.r_in   = onehot(rx_q);
                bus.done   = 1'b1;
                state_nxt  = S_IDLE;
            end
            S_ERR: begin
                bus.done  = 1'b1;
                bus.err   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                bus.busy  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_ctrl_seq.sv
// Directed plus random stimulus for proc_ctrl_seq; expected per-cycle outputs queued at issue time
// and compared one per clock, 1 time unit after the rising edge.
module tb_proc_ctrl_seq;

    localparam int NR = 4;
    localparam int IW = 3;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          err;
        logic          data_out;
        logic [NR-1:0] r_in;
        logic [NR-1:0] r_out;
        logic          a_in;
        logic          g_in;
        logic          g_out;
        logic [2:0]    alu_op;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];
    obs_t obs;

    proc_ctrl_seq_if #(.NUM_REGS(NR), .IDX_W(IW)) bus ();

    proc_ctrl_seq #(.NUM_REGS(NR), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign obs = '{busy: bus.busy, done: bus.done, err: bus.err, data_out: bus.data_out,
                   r_in: bus.r_in, r_out: bus.r_out, a_in: bus.a_in, g_in: bus.g_in,
                   g_out: bus.g_out, alu_op: bus.alu_op};

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] one;
        one = 1;
        return one << i;
    endfunction

    // Reference model: queue the output vector for every busy cycle of one instruction.
    task automatic push_instr(input logic [3:0] f, input logic [IW-1:0] x, input logic [IW-1:0] y);
        int   code;
        bit   legal;
        obs_t e;
        code = -1;
        case (f)
            4'd3: code = 0;
            4'd4: code = 1;
            4'd5: code = 2;
`ifdef LOGIC_OPS_EN
            4'd6: code = 3;
            4'd7: code = 4;
`endif
            default: code = -1;
        endcase
        legal = (int'(x) < NR) && ((f == 4'd1) || (((f == 4'd2) || (code >= 0)) && (int'(y) < NR)));
        e = '0;
        e.busy = 1'b1;
        if (!legal) begin
            e.done = 1'b1; e.err = 1'b1;
            sb.push_back(e);
        end else if (f == 4'd1) begin
            e.done = 1'b1; e.data_out = 1'b1; e.r_in = oh(int'(x));
            sb.push_back(e);
        end else if (f == 4'd2) begin
            e.done = 1'b1; e.r_out = oh(int'(y)); e.r_in = oh(int'(x));
            sb.push_back(e);
        end else begin
            e.alu_op = 3'(code);
            e.r_out = oh(int'(x)); e.a_in = 1'b1;
            sb.push_back(e);
            e.a_in = 1'b0; e.r_out = oh(int'(y)); e.g_in = 1'b1;
            sb.push_back(e);
            e.g_in = 1'b0; e.r_out = '0; e.g_out = 1'b1; e.r_in = oh(int'(x)); e.done = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic check(input string tag, input obs_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; compare against the next queued vector, or against idle when nothing is queued.
    task automatic cyc(input string tag);
        obs_t exp;
        @(posedge clk);
        #1;
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        check(tag, exp);
    endtask

    task automatic run(input string tag, input logic [3:0] f, input logic [IW-1:0] x, input logic [IW-1:0] y);
        int n;
        bus.func = f; bus.rx = x; bus.ry = y; bus.start = 1'b1;
        push_instr(f, x, y);
        n = sb.size();
        cyc(tag);
        bus.start = 1'b0;
        bus.func  = 4'($urandom);
        bus.rx    = IW'($urandom);
        bus.ry    = IW'($urandom);
        for (int i = 1; i < n; i++) cyc(tag);
        cyc({tag, "_idle"});
    endtask

    initial begin
        bus.start = 1'b0; bus.func = '0; bus.rx = '0; bus.ry = '0;
        #1;
        check("reset_state", '0);
        #11;
        rst_n = 1'b1;
        cyc("post_reset_idle");

        run("load_r2",      4'b0001, 3'd2, 3'd0);
        run("load_ry_unused", 4'b0001, 3'd1, 3'd7);
        run("move_1_3",     4'b0010, 3'd1, 3'd3);
        run("move_same",    4'b0010, 3'd2, 3'd2);
        run("add_1_3",      4'b0011, 3'd1, 3'd3);
        run("sub_0_2",      4'b0100, 3'd0, 3'd2);
        run("xor_same",     4'b0101, 3'd3, 3'd3);
        run("and_0_1",      4'b0110, 3'd0, 3'd1);
        run("or_2_3",       4'b0111, 3'd2, 3'd3);
        run("ill_ry5",      4'b0011, 3'd1, 3'd5);
        run("ill_f15",      4'b1111, 3'd0, 3'd0);
        run("ill_f0",       4'b0000, 3'd0, 3'd0);
        run("ill_f8",       4'b1000, 3'd1, 3'd1);
        run("ill_rx4",      4'b0001, 3'd4, 3'd0);
        run("ill_move_ry4", 4'b0010, 3'd0, 3'd4);
        run("ill_alu_rx4",  4'b0101, 3'd4, 3'd0);

        // start held high with a new opcode during ADD: accepted only on the first IDLE edge.
        bus.func = 4'b0011; bus.rx = 3'd1; bus.ry = 3'd3; bus.start = 1'b1;
        push_instr(4'b0011, 3'd1, 3'd3);
        sb.push_back('0);
        push_instr(4'b0001, 3'd0, 3'd0);
        cyc("hs_t1");
        bus.func = 4'b0001; bus.rx = 3'd0; bus.ry = 3'd0;
        cyc("hs_t2");
        cyc("hs_t3_done1");
        cyc("hs_gap_idle");
        cyc("hs_load_done2");
        bus.start = 1'b0;
        cyc("hs_end_idle");

        // Reset in ADD T2 aborts the instruction with no done pulse.
        bus.func = 4'b0011; bus.rx = 3'd1; bus.ry = 3'd3; bus.start = 1'b1;
        push_instr(4'b0011, 3'd1, 3'd3);
        cyc("rst_t1");
        bus.start = 1'b0;
        cyc("rst_t2");
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("rst_async_clear", '0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rst_no_done");
        cyc("rst_idle2");

        for (int k = 0; k < 30; k++) begin
            logic [3:0]    rf;
            logic [IW-1:0] rxv, ryv;
            rf  = 4'($urandom_range(0, 8));
            rxv = IW'($urandom_range(0, 4));
            ryv = IW'($urandom_range(0, 4));
            run("random", rf, rxv, ryv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
